decomp_ctrl: RTL

Decompressor control unit sitting directly upstream of the instruction decoder: consumes 32-bit words from the instruction-memory stream and emits one uncompressed 32-bit instruction per handshake. Compressed words carry two token indices that are expanded through an internal token table. Raw words pass through unchanged. The output stream feeds the decoder's instruction input.

---
 rtl/decomp_pkg.sv | 14 +
 rtl/decomp_ctrl_token_table.sv | 29 ++
 rtl/decomp_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/decomp_pkg.sv
// Shared types and constants for the instruction decompressor control unit.
package decomp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAW   = 2'd1,
    OUT_A = 2'd2,
    OUT_B = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'hE1A00000;
  localparam logic [15:0] PAD_IDX   = 16'hFFFF;

endpackage

// File: rtl/decomp_ctrl_token_table.sv
// Token table RAM: one synchronous write port and one synchronous read port.
// A read and a write of the same address in one cycle return the old data.
module token_table #(
  parameter int WIDTH    = 32,
  parameter int TT_DEPTH = 256,
  parameter int TT_AW    = $clog2(TT_DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [TT_AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [TT_AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [TT_DEPTH];

  // rdata only moves on an issued read, so a stalled output keeps its value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/decomp_ctrl.sv
// Decompressor control: passes raw words through and expands compressed words
// into two token-table entries. Define DECOMP_PERF_CNT_EN to build the counters.
module decomp_ctrl
  import decomp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int TT_DEPTH = 256,
  parameter int TT_AW    = $clog2(TT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_cmp,
  input  logic             tt_we,
  input  logic [TT_AW-1:0] tt_waddr,
  input  logic [WIDTH-1:0] tt_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic             out_tok,
  output logic             err,
  output logic [31:0]      cnt_raw,
  output logic [31:0]      cnt_tok
);

  state_t           state;
  logic [WIDTH-1:0] raw_word;
  logic [15:0]      idx_b;
  logic             slot_nop;
  logic [15:0]      idx_a;
  logic             a_ok;
  logic             b_ok;
  logic             rd_en;
  logic [TT_AW-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;

  assign idx_a = in_word[15:0];
  // PAD is only meaningful in slot b; in slot a it is just another bad index.
  assign a_ok  = ((idx_a >> TT_AW) == 16'd0) && (idx_a != PAD_IDX);
  assign b_ok  = ((idx_b >> TT_AW) == 16'd0);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state != IDLE);
  assign out_tok   = (state == OUT_A) || (state == OUT_B);

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = idx_a[TT_AW-1:0];
    if (state == IDLE && in_valid && in_cmp) begin
      rd_en = a_ok;
    end else if (state == OUT_A && out_ready && idx_b != PAD_IDX) begin
      rd_en   = b_ok;
      rd_addr = idx_b[TT_AW-1:0];
    end
  end

  token_table #(
    .WIDTH   (WIDTH),
    .TT_DEPTH(TT_DEPTH),
    .TT_AW   (TT_AW)
  ) u_table (
    .clk  (clk),
    .we   (tt_we),
    .waddr(tt_waddr),
    .wdata(tt_wdata),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // out_instr depends only on registered state, never on out_ready.
  always_comb begin
    out_instr = '0;
    case (state)
      RAW:          out_instr = raw_word;
      OUT_A, OUT_B: out_instr = slot_nop ? NOP_INSTR : rd_data;
      default:      out_instr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      raw_word <= '0;
      idx_b    <= '0;
      slot_nop <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!in_cmp) begin
              raw_word <= in_word;
              state    <= RAW;
            end else begin
              idx_b    <= in_word[31:16];
              slot_nop <= !a_ok;
              if (!a_ok) err <= 1'b1;
              state    <= OUT_A;
            end
          end
        end
        RAW: begin
          if (out_ready) state <= IDLE;
        end
        OUT_A: begin
          if (out_ready) begin
            if (idx_b == PAD_IDX) begin
              state <= IDLE;
            end else begin
              slot_nop <= !b_ok;
              if (!b_ok) err <= 1'b1;
              state    <= OUT_B;
            end
          end
        end
        OUT_B: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DECOMP_PERF_CNT_EN
  // Saturating handshake counters; token count includes NOP substitutions.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_raw <= '0;
      cnt_tok <= '0;
    end else begin
      if (state == RAW && out_ready && cnt_raw != 32'hFFFFFFFF) begin
        cnt_raw <= cnt_raw + 32'd1;
      end
      if (out_tok && out_ready && cnt_tok != 32'hFFFFFFFF) begin
        cnt_tok <= cnt_tok + 32'd1;
      end
    end
  end
`else
  assign cnt_raw = 32'd0;
  assign cnt_tok = 32'd0;
`endif

endmodule
